// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/halfword loads and stores onto an 8-bit memory.
// Ports: clk, rst (async, high); req_* valid/ready request; resp_* one-cycle
// response (rdata, err); mem_* byte-wide memory port (read data one cycle late).
module load_store_unit #(
   parameter int unsigned MEM_DEPTH = 16384
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_size,
   input  logic        req_signed,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic [15:0] mem_daddr,
   output logic [7:0]  mem_data_in,
   output logic        mem_we,
   output logic        mem_read_e,
   input  logic [15:0] mem_data_out
);

   localparam logic [16:0] LP_DEPTH = 17'(MEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_WR0, S_WR1, S_RD0, S_RD1, S_RD2, S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_size;
   logic        r_signed;
   logic [7:0]  r_lo;
   logic [15:0] r_rdata;
   logic        r_err;

   logic [16:0] w_addr1;
   logic        w_err;
   logic [15:0] w_addr_hi;
   logic [15:0] w_rdata;
   logic        w_unused;

   // 17-bit increment so 0xFFFF + 1 cannot wrap back into range
   assign w_addr1   = {1'b0, req_addr} + 17'd1;
   assign w_err     = ({1'b0, req_addr} >= LP_DEPTH) ||
                      (req_size && (w_addr1 >= LP_DEPTH));
   // only reached for in-range halfwords, so no overflow here
   assign w_addr_hi = r_addr + 16'd1;
   assign w_unused  = ^mem_data_out[15:8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      mem_we      = 1'b0;
      mem_read_e  = 1'b0;
      mem_daddr   = 16'h0000;
      mem_data_in = 8'h00;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_err)       w_next = S_RESP;
               else if (req_we) w_next = S_WR0;
               else             w_next = S_RD0;
            end
         end
         S_WR0: begin
            mem_we      = 1'b1;
            mem_daddr   = r_addr;
            mem_data_in = r_wdata[7:0];
            w_next      = r_size ? S_WR1 : S_RESP;
         end
         S_WR1: begin
            mem_we      = 1'b1;
            mem_daddr   = w_addr_hi;
            mem_data_in = r_wdata[15:8];
            w_next      = S_RESP;
         end
         S_RD0: begin
            mem_read_e = 1'b1;
            mem_daddr  = r_addr;
            w_next     = S_RD1;
         end
         S_RD1: begin
            if (r_size) begin
               mem_read_e = 1'b1;
               mem_daddr  = w_addr_hi;
               w_next     = S_RD2;
            end else begin
               w_next = S_RESP;
            end
         end
         S_RD2:   w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // data presented at RESP; only RD1 (byte) and RD2 (halfword) feed it
   always_comb begin
      w_rdata = 16'h0000;
      if (r_state == S_RD1) begin
         if (r_signed) w_rdata = {{8{mem_data_out[7]}}, mem_data_out[7:0]};
         else          w_rdata = {8'h00, mem_data_out[7:0]};
      end else if (r_state == S_RD2) begin
         w_rdata = {mem_data_out[7:0], r_lo};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr   <= 16'h0000;
         r_wdata  <= 16'h0000;
         r_size   <= 1'b0;
         r_signed <= 1'b0;
         r_lo     <= 8'h00;
         r_rdata  <= 16'h0000;
         r_err    <= 1'b0;
      end else begin
         if (r_state == S_IDLE && req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_size   <= req_size;
            r_signed <= req_signed;
         end
         if (r_state == S_RD1) begin
            r_lo <= mem_data_out[7:0];
         end
         // response registers change only on entry to RESP, then hold
         if (w_next == S_RESP) begin
            r_err   <= (r_state == S_IDLE);
            r_rdata <= w_rdata;
         end
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
